// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file, control decode,
// hazard detection and beq/bne/j resolution. Optional macro RF_BYPASS_EN: write-before-read register file.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] PC_if,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  input  logic        MemRead_ex,
  input  logic        RegWrite_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        MemRead_mem,
  input  logic [4:0]  WriteReg_mem,
  output logic        IFWrite,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic [31:0] PCplus4_id,
  output logic [31:0] Instruction_id,
  output logic [31:0] RsData_id,
  output logic [31:0] RtData_id,
  output logic [31:0] Imm_id,
  output logic [4:0]  Rs_id,
  output logic [4:0]  Rt_id,
  output logic [4:0]  Rd_id,
  output logic        RegWrite_id,
  output logic        MemRead_id,
  output logic        MemWrite_id,
  output logic        MemtoReg_id,
  output logic        ALUSrc_id,
  output logic        RegDst_id,
  output logic [1:0]  ALUOp_id
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  logic [31:0] rf [32];
  logic [5:0]  opcode;
  logic        is_branch;
  logic        load_use;
  logic        br_hazard;
  logic        stall;
  logic        operands_equal;
  logic        taken;

  // IF/ID register: stall holds, redirect squashes the wrong-path instruction
  always_ff @(posedge clk) begin
    if (!reset) begin
      Instruction_id <= '0;
      PCplus4_id     <= '0;
    end else if (stall) begin
      Instruction_id <= Instruction_id;
      PCplus4_id     <= PCplus4_id;
    end else if (Branch || Jump) begin
      Instruction_id <= '0;
    end else begin
      Instruction_id <= Instruction_if;
      PCplus4_id     <= PC_if + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite_wb && (WriteReg_wb != 5'd0)) begin
      rf[WriteReg_wb] <= WriteData_wb;
    end
  end

  assign opcode = Instruction_id[31:26];
  assign Rs_id  = Instruction_id[25:21];
  assign Rt_id  = Instruction_id[20:16];
  assign Rd_id  = Instruction_id[15:11];
  assign Imm_id = {{16{Instruction_id[15]}}, Instruction_id[15:0]};

`ifdef RF_BYPASS_EN
  assign RsData_id = (Rs_id == 5'd0) ? 32'd0 :
                     (RegWrite_wb && (WriteReg_wb == Rs_id)) ? WriteData_wb : rf[Rs_id];
  assign RtData_id = (Rt_id == 5'd0) ? 32'd0 :
                     (RegWrite_wb && (WriteReg_wb == Rt_id)) ? WriteData_wb : rf[Rt_id];
`else
  assign RsData_id = (Rs_id == 5'd0) ? 32'd0 : rf[Rs_id];
  assign RtData_id = (Rt_id == 5'd0) ? 32'd0 : rf[Rt_id];
`endif

  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign load_use  = MemRead_ex && (WriteReg_ex != 5'd0) &&
                     ((WriteReg_ex == Rs_id) || (WriteReg_ex == Rt_id));
  // Branches compare in ID, so they must also wait for ALU results in EX and loads in MEM
  assign br_hazard = is_branch &&
                     ((RegWrite_ex && (WriteReg_ex != 5'd0) &&
                       ((WriteReg_ex == Rs_id) || (WriteReg_ex == Rt_id))) ||
                      (MemRead_mem && (WriteReg_mem != 5'd0) &&
                       ((WriteReg_mem == Rs_id) || (WriteReg_mem == Rt_id))));
  assign stall     = load_use || br_hazard;
  assign IFWrite   = !stall;

  assign operands_equal = (RsData_id == RtData_id);
  assign taken = ((opcode == OP_BEQ) && operands_equal) ||
                 ((opcode == OP_BNE) && !operands_equal);

  always_comb begin
    RegWrite_id = 1'b0;
    MemRead_id  = 1'b0;
    MemWrite_id = 1'b0;
    MemtoReg_id = 1'b0;
    ALUSrc_id   = 1'b0;
    RegDst_id   = 1'b0;
    ALUOp_id    = 2'b00;
    Branch      = 1'b0;
    Jump        = 1'b0;
    JumpAddr    = 32'd0;
    // The all-zero word is the pipeline nop/bubble, not an R-type write to $0
    if (!stall && (Instruction_id != 32'd0)) begin
      case (opcode)
        OP_RTYPE: begin
          RegDst_id   = 1'b1;
          RegWrite_id = 1'b1;
          ALUOp_id    = 2'b10;
        end
        OP_LW: begin
          ALUSrc_id   = 1'b1;
          MemRead_id  = 1'b1;
          MemtoReg_id = 1'b1;
          RegWrite_id = 1'b1;
        end
        OP_SW: begin
          ALUSrc_id   = 1'b1;
          MemWrite_id = 1'b1;
        end
        OP_ADDI: begin
          ALUSrc_id   = 1'b1;
          RegWrite_id = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          ALUOp_id = 2'b01;
          if (taken) begin
            Branch   = 1'b1;
            JumpAddr = PCplus4_id + {Imm_id[29:0], 2'b00};
          end
        end
        OP_J: begin
          Jump     = 1'b1;
          JumpAddr = {PCplus4_id[31:28], Instruction_id[25:0], 2'b00};
        end
        default: ;
      endcase
    end
  end
endmodule
